// File: rtl/bram_wnd_reader.sv
// bram_wnd_reader
//
// Read side of the greyscale line buffer. The BRAM holds NLINES lines of HRES
// pixels in a circular arrangement. Once three complete lines are available
// the reader streams vertical 3-pixel columns (rows y, y+1, y+2) for every x of
// a row to a downstream 3x3 filter. At the end of each row the oldest line is
// released with a pixel_ack pulse so the writer can refill it. After the last
// row of a frame the two remaining lines are released and frame_done pulses.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wnd_in_bram       writer has filled the buffer at least once
//   bram_wr_en        writer's per-pixel BRAM write strobe (line credit source)
//   bram_rd_en        BRAM read enable
//   bram_addr         BRAM read address
//   bram_data         BRAM read data, grey value in [7:0], 1-cycle latency
//   pixel_ack         one-cycle pulse: oldest line released
//   out_valid/ready   column handshake
//   out_px0..2        pixels at rows y, y+1, y+2
//   out_x, out_y      column index and top row index
//   out_last          column is the last of its row
//   frame_done        one-cycle pulse after the final release of a frame
module bram_wnd_reader #(
    parameter int HRES   = 640,
    parameter int VRES   = 480,
    parameter int NLINES = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wnd_in_bram,
    input  logic              bram_wr_en,
    output logic              bram_rd_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [15:0]       bram_data,
    output logic              pixel_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_px0,
    output logic [7:0]        out_px1,
    output logic [7:0]        out_px2,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic              out_last,
    output logic              frame_done
);

    localparam int TOP_W = (NLINES > 1) ? $clog2(NLINES) : 1;
    localparam int RA_W  = $clog2(NLINES + 1);
    localparam int WC_W  = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [ADDR_W-1:0] HRES_A = ADDR_W'(HRES);
    // May truncate to 0 when the buffer exactly fills the address space; the
    // base arithmetic is modulo 2^ADDR_W, so the result is still correct.
    localparam logic [ADDR_W-1:0] TOT_A  = ADDR_W'(NLINES * HRES);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_ACK, S_FLUSH} state_t;

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [TOP_W-1:0]  top, top_n;
    logic [ADDR_W-1:0] top_base, top_base_n;   // top * HRES, tracked incrementally
    logic [ADDR_W-1:0] base1, base2;
    logic [9:0]        x, x_n, y, y_n;
    logic [RA_W-1:0]   rows_avail, ra_n;
    logic [WC_W-1:0]   wr_cnt, wr_cnt_n;
    logic              wrap, advance_top;

    logic              rd_en_n, ack_n, valid_n, last_n, fdone_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        px0_n, px1_n, px2_n;
    logic [9:0]        ox_n, oy_n;

    logic              unused_hi;
    assign unused_hi = ^bram_data[15:8];

    // Bases of rows top+1 and top+2: add HRES, subtract the buffer size on wrap
    always_comb begin
        base1 = top_base + HRES_A - ((top == TOP_W'(NLINES - 1)) ? TOT_A : '0);
        base2 = top_base + HRES_A + HRES_A
              - ((top >= TOP_W'(NLINES - 2)) ? TOT_A : '0);
    end

    // Line credits: a completed line adds one, a release removes one
    always_comb begin
        wrap     = bram_wr_en && (wr_cnt == WC_W'(HRES - 1));
        wr_cnt_n = wr_cnt;
        if (bram_wr_en)
            wr_cnt_n = wrap ? '0 : wr_cnt + 1'b1;
        ra_n = rows_avail;
        if (wrap && !pixel_ack && rows_avail != RA_W'(NLINES))
            ra_n = rows_avail + 1'b1;
        else if (pixel_ack && !wrap && rows_avail != '0)
            ra_n = rows_avail - 1'b1;
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        x_n         = x;
        y_n         = y;
        top_n       = top;
        top_base_n  = top_base;
        advance_top = 1'b0;
        valid_n     = out_valid;
        px0_n       = out_px0;
        px1_n       = out_px1;
        px2_n       = out_px2;
        ox_n        = out_x;
        oy_n        = out_y;
        last_n      = out_last;
        rd_en_n     = 1'b0;
        addr_n      = bram_addr;

        case (state)
            S_IDLE: begin
                if (wnd_in_bram && rows_avail >= RA_W'(3)) begin
                    state_n = S_FETCH;
                    cnt_n   = '0;
                end
            end
            // cnt 0..2 present the three addresses; data trails by one cycle,
            // so cnt 1..3 capture rows 0..2.
            S_FETCH: begin
                cnt_n = cnt + 3'd1;
                case (cnt)
                    3'd1: px0_n = bram_data[7:0];
                    3'd2: px1_n = bram_data[7:0];
                    3'd3: begin
                        px2_n   = bram_data[7:0];
                        state_n = S_HOLD;
                        cnt_n   = '0;
                        valid_n = 1'b1;
                        ox_n    = x;
                        oy_n    = y;
                        last_n  = (x == 10'(HRES - 1));
                    end
                    default: ;
                endcase
            end
            S_HOLD: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    if (x == 10'(HRES - 1)) begin
                        x_n     = '0;
                        state_n = S_ACK;
                    end else begin
                        x_n     = x + 10'd1;
                        state_n = S_FETCH;
                        cnt_n   = '0;
                    end
                end
            end
            S_ACK: begin
                advance_top = 1'b1;
                if (y < 10'(VRES - 3)) begin
                    y_n     = y + 10'd1;
                    state_n = S_IDLE;
                end else begin
                    state_n = S_FLUSH;
                    cnt_n   = '0;
                end
            end
            // gap, ack, gap, ack, gap, frame_done
            S_FLUSH: begin
                if (cnt == 3'd1 || cnt == 3'd3)
                    advance_top = 1'b1;
                if (cnt == 3'd5) begin
                    state_n = S_IDLE;
                    y_n     = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (advance_top) begin
            top_n      = (top == TOP_W'(NLINES - 1)) ? '0 : top + 1'b1;
            top_base_n = base1;
        end

        // Outputs are registered, so they are derived from the state being entered
        if (state_n == S_FETCH && cnt_n < 3'd3) begin
            rd_en_n = 1'b1;
            case (cnt_n)
                3'd0:    addr_n = top_base + ADDR_W'(x_n);
                3'd1:    addr_n = base1 + ADDR_W'(x_n);
                default: addr_n = base2 + ADDR_W'(x_n);
            endcase
        end
        ack_n   = (state_n == S_ACK) ||
                  (state_n == S_FLUSH && (cnt_n == 3'd1 || cnt_n == 3'd3));
        fdone_n = (state_n == S_FLUSH) && (cnt_n == 3'd5);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            top        <= '0;
            top_base   <= '0;
            x          <= '0;
            y          <= '0;
            rows_avail <= '0;
            wr_cnt     <= '0;
            bram_rd_en <= 1'b0;
            bram_addr  <= '0;
            pixel_ack  <= 1'b0;
            out_valid  <= 1'b0;
            out_px0    <= '0;
            out_px1    <= '0;
            out_px2    <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            top        <= top_n;
            top_base   <= top_base_n;
            x          <= x_n;
            y          <= y_n;
            rows_avail <= ra_n;
            wr_cnt     <= wr_cnt_n;
            bram_rd_en <= rd_en_n;
            bram_addr  <= addr_n;
            pixel_ack  <= ack_n;
            out_valid  <= valid_n;
            out_px0    <= px0_n;
            out_px1    <= px1_n;
            out_px2    <= px2_n;
            out_x      <= ox_n;
            out_y      <= oy_n;
            out_last   <= last_n;
            frame_done <= fdone_n;
        end
    end

endmodule

// File: tb/tb_bram_wnd_reader.sv
// Testbench for bram_wnd_reader with a reduced frame (16x16, 8-line buffer).
// A behavioural writer fills a BRAM model from a random image table, released
// lines are tracked from pixel_ack, and every column, address and pulse is
// compared against what the image and line bookkeeping say it must be.
module tb_bram_wnd_reader;

    localparam int HRES   = 16;
    localparam int VRES   = 16;
    localparam int NLINES = 8;
    localparam int ADDR_W = 7;
    localparam int MAXL   = 128;
    localparam int LIM    = 20000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wnd_in_bram = 1'b0;
    logic              bram_wr_en = 1'b0;
    logic              out_ready = 1'b0;
    logic [15:0]       bram_data = '0;
    logic              bram_rd_en;
    logic [ADDR_W-1:0] bram_addr;
    logic              pixel_ack;
    logic              out_valid;
    logic [7:0]        out_px0, out_px1, out_px2;
    logic [9:0]        out_x, out_y;
    logic              out_last;
    logic              frame_done;

    always #5 clk = ~clk;

    bram_wnd_reader #(.HRES(HRES), .VRES(VRES), .NLINES(NLINES), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .wnd_in_bram(wnd_in_bram), .bram_wr_en(bram_wr_en),
        .bram_rd_en(bram_rd_en), .bram_addr(bram_addr), .bram_data(bram_data),
        .pixel_ack(pixel_ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_px0(out_px0), .out_px1(out_px1), .out_px2(out_px2),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .frame_done(frame_done)
    );

    logic [15:0] mem    [0:NLINES*HRES-1];
    logic [15:0] pixtab [0:MAXL*HRES-1];

    always @(posedge clk)
        if (bram_rd_en) bram_data <= mem[bram_addr];

    int n_chk = 0, n_pass = 0;
    int cyc = 0, ep_off = 0, wr_line = 0, wr_x = 0, rel = 0;
    int rd_fr = 0, rd_y = 0, rd_x = 0, rd_seq = 0, rise_cyc = 0, hs_cyc = 0;
    int acks_frame = 0, frames_done = 0, hold_cnt = 0, wr_rate = 100;
    bit prev_ack = 0, prev_valid = 0, prev_hs = 0, bp_done = 0, force_nr = 0, wr_allow = 0;
    logic [44:0] snap = '0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        int l;
        logic [44:0] cur;
        bit hs;
        cyc++;
        if (pixel_ack) begin
            chk("ack_gap", prev_ack, 0);
            rel++;
            acks_frame++;
        end
        prev_ack = pixel_ack;
        if (frame_done) begin
            chk("frame_acks", acks_frame, VRES);
            chk("frame_pos", rd_y * HRES + rd_x, 0);
            acks_frame = 0;
            frames_done++;
        end

        l = rd_fr * VRES + rd_y;
        if (bram_rd_en) begin
            chk("rd_in_hold", out_valid, 0);
            if (rd_seq == 0) begin
                rise_cyc = cyc;
                if (rd_x == 0) begin
                    chk("row_credit", wr_line >= l + 3, 1);
                    chk("row_acks", rel, l);
                end else begin
                    chk("col_period", cyc - hs_cyc, 1);
                end
            end
            chk("rd_len", rd_seq < 3, 1);
            if (rd_seq < 3)
                chk("rd_addr", bram_addr, ((l + rd_seq) % NLINES) * HRES + rd_x);
            rd_seq++;
        end else begin
            if (rd_seq != 0) chk("rd_burst", rd_seq, 3);
            rd_seq = 0;
        end

        cur = {out_px0, out_px1, out_px2, out_x, out_y, out_last};
        if (prev_hs) begin
            chk("vld_after_hs", out_valid, 0);
        end else if (prev_valid) begin
            chk("vld_hold", out_valid, 1);
            if (out_valid) chk("hold_stable", cur, snap);
        end else if (out_valid) begin
            chk("vld_lat", cyc - rise_cyc, 4);
            chk("px0", out_px0, pixtab[(ep_off + l) * HRES + rd_x][7:0]);
            chk("px1", out_px1, pixtab[(ep_off + l + 1) * HRES + rd_x][7:0]);
            chk("px2", out_px2, pixtab[(ep_off + l + 2) * HRES + rd_x][7:0]);
            chk("out_x", out_x, rd_x);
            chk("out_y", out_y, rd_y);
            chk("out_last", out_last, rd_x == HRES - 1);
            snap = cur;
        end

        if (force_nr) begin
            out_ready = 1'b0;
        end else if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else if (out_valid && !prev_valid && !bp_done && rd_x == 5 && rd_y == 0 && rd_fr == 0) begin
            bp_done   = 1;
            hold_cnt  = 19;
            out_ready = 1'b0;
        end else begin
            out_ready = ($urandom_range(0, 3) != 0);
        end

        hs = out_valid && out_ready;
        if (hs) begin
            hs_cyc = cyc;
            if (rd_x == HRES - 1) begin
                rd_x = 0;
                if (rd_y == VRES - 3) begin
                    rd_y = 0;
                    rd_fr++;
                end else begin
                    rd_y++;
                end
            end else begin
                rd_x++;
            end
        end
        prev_hs    = hs;
        prev_valid = out_valid && !hs;

        bram_wr_en = 1'b0;
        if (wr_allow && (wr_line - rel) < NLINES && (ep_off + wr_line) < MAXL &&
            int'($urandom_range(0, 99)) < wr_rate) begin
            bram_wr_en = 1'b1;
            mem[(wr_line % NLINES) * HRES + wr_x] = pixtab[(ep_off + wr_line) * HRES + wr_x];
            if (wr_x == HRES - 1) begin
                wr_x = 0;
                wr_line++;
            end else begin
                wr_x++;
            end
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < MAXL * HRES; i++) pixtab[i] = 16'($urandom);
        for (int i = 0; i < NLINES * HRES; i++) mem[i] = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outs", {bram_rd_en, bram_addr, out_valid, out_px0, out_px1, out_px2,
                         out_x, out_y, out_last, frame_done}, 0);
        chk("rst_ack", pixel_ack, 0);
        rst = 1'b0;
        wnd_in_bram = 1'b1;
        wr_allow = 1;

        // fast fill, first row with a long stall on x=5
        wr_rate = 100;
        n = 0;
        while (!(rd_fr == 0 && rd_y == 1) && n < LIM) begin @(negedge clk); step(); n++; end
        chk("t_row1", n < LIM, 1);

        // slow writer: reader repeatedly waits for line credits
        wr_rate = 20;
        n = 0;
        while (rd_fr < 1 && n < LIM) begin @(negedge clk); step(); n++; end
        chk("t_frame0", n < LIM, 1);

        // writer stalled outright, then resumed
        wr_allow = 0;
        repeat (200) begin @(negedge clk); step(); end
        wr_allow = 1;
        wr_rate = 60;
        n = 0;
        while (!(rd_fr == 2 && rd_y == 3 && rd_x == 7) && n < LIM) begin @(negedge clk); step(); n++; end
        chk("t_frame1", n < LIM, 1);
        chk("frames", frames_done, 2);

        // reset while a column is held
        force_nr = 1;
        n = 0;
        while (!out_valid && n < 2000) begin @(negedge clk); step(); n++; end
        chk("t_hold", n < 2000, 1);
        rst = 1'b1;
        bram_wr_en = 1'b0;
        @(negedge clk);
        chk("rst_hold_outs", {bram_rd_en, bram_addr, out_valid, out_px0, out_px1, out_px2,
                              out_x, out_y, out_last, frame_done}, 0);
        chk("rst_hold_ack", pixel_ack, 0);
        rst = 1'b0;
        ep_off = 64; wr_line = 0; wr_x = 0; rel = 0;
        rd_fr = 0; rd_y = 0; rd_x = 0; rd_seq = 0; rise_cyc = 0; hs_cyc = 0;
        acks_frame = 0; hold_cnt = 0; force_nr = 0;
        prev_ack = 0; prev_valid = 0; prev_hs = 0;

        wr_rate = 100;
        n = 0;
        while (!(rd_fr == 0 && rd_y == 2) && n < LIM) begin @(negedge clk); step(); n++; end
        chk("t_refill", n < LIM, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
